// File: rtl/fadd_pipe.sv
// Pipelined IEEE-style add/sub: align -> add/normalise -> round-to-nearest-even.
// Denormal inputs and underflowing results are flushed to zero.
module fadd_pipe #(
    parameter int EW = 8,
    parameter int MW = 23,
    localparam int W = 1 + EW + MW
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         ovf,
    output logic         zero
);
    localparam int SW = MW + 4;   // hidden + mantissa + guard/round/sticky
    localparam int STAGES = 3;
    localparam logic [EW-1:0] EMAX = '1;

    logic [STAGES:1] vld_q;
    logic            advance;

    // Stage 1: align
    logic [EW-1:0]       e1, e2, be, se, ediff;
    logic [MW-1:0]       m1, m2;
    logic                s2e, z1, z2, swap;
    logic [EW+MW-1:0]    mag1, mag2;
    logic [SW-1:0]       sig1, sig2, ssig;
    logic [2*SW-1:0]     ext;
    logic [31:0]         sh;
    logic [SW-1:0]       s1_big_d, s1_small_d, s1_big_q, s1_small_q;
    logic [EW-1:0]       s1_exp_d, s1_exp_q;
    logic                s1_sign_d, s1_sub_d, s1_spec_d, s1_spec_sign_d, s1_negz_d;
    logic                s1_sign_q, s1_sub_q, s1_spec_q, s1_spec_sign_q, s1_negz_q;

    always_comb begin
        e1   = x1[W-2:MW];
        e2   = x2[W-2:MW];
        m1   = x1[MW-1:0];
        m2   = x2[MW-1:0];
        s2e  = x2[W-1] ^ sub;
        z1   = (e1 == '0);
        z2   = (e2 == '0);
        mag1 = z1 ? '0 : {e1, m1};
        mag2 = z2 ? '0 : {e2, m2};
        sig1 = z1 ? '0 : {1'b1, m1, 3'b000};
        sig2 = z2 ? '0 : {1'b1, m2, 3'b000};
        swap = (mag2 > mag1);
        be   = swap ? e2 : e1;
        se   = swap ? e1 : e2;
        ssig = swap ? sig1 : sig2;
        ediff = be - se;
        sh   = (32'(ediff) > 32'(MW + 3)) ? 32'(MW + 3) : 32'(ediff);
        // Everything shifted below the round position collapses into sticky
        ext  = {ssig, {SW{1'b0}}} >> sh;
        s1_small_d     = {ext[2*SW-1:SW+1], ext[SW] | (|ext[SW-1:0])};
        s1_big_d       = swap ? sig2 : sig1;
        s1_exp_d       = be;
        s1_sign_d      = swap ? s2e : x1[W-1];
        s1_sub_d       = x1[W-1] ^ s2e;
        s1_spec_d      = (e1 == EMAX) | (e2 == EMAX);
        s1_spec_sign_d = (e2 > e1) ? s2e : x1[W-1];
        s1_negz_d      = x1[W-1] & s2e;
    end

    // Stage 2: add/subtract and normalise
    logic [SW:0]    sum;
    int             lz, en;
    logic [SW-1:0]  s2_sig_d, s2_sig_q;
    logic [EW:0]    s2_exp_d, s2_exp_q;
    logic           s2_sign_d, s2_sign_q, s2_spec_d, s2_spec_q;

    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                       : ({1'b0, s1_big_q} + {1'b0, s1_small_q});
        lz = 0;
        for (int i = 0; i < SW; i++)
            if (sum[i]) lz = SW - 1 - i;
        en        = 0;
        s2_sig_d  = '0;
        s2_exp_d  = '0;
        s2_sign_d = s1_sign_q;
        s2_spec_d = s1_spec_q;
        if (s1_spec_q) begin
            s2_sign_d = s1_spec_sign_q;
        end else if (sum == '0) begin
            s2_sign_d = s1_negz_q;
        end else if (sum[SW]) begin
            s2_sig_d = {sum[SW:2], sum[1] | sum[0]};
            s2_exp_d = {1'b0, s1_exp_q} + 1'b1;
        end else begin
            en = int'({1'b0, s1_exp_q}) - lz;
            if (en <= 0) begin
                s2_sign_d = 1'b0;
            end else begin
                s2_sig_d = sum[SW-1:0] << lz;
                s2_exp_d = en[EW:0];
            end
        end
    end

    // Stage 3: round; a clear hidden bit marks a zero result
    logic          inc;
    logic [MW:0]   rnd;
    logic [EW:0]   e3;
    logic [W-1:0]  y_d, y_q;
    logic          ovf_d, ovf_q, zero_d, zero_q;

    always_comb begin
        inc   = s2_sig_q[2] & (s2_sig_q[1] | s2_sig_q[0] | s2_sig_q[3]);
        rnd   = {1'b0, s2_sig_q[SW-2:3]} + {{MW{1'b0}}, inc};
        e3    = s2_exp_q + {{EW{1'b0}}, rnd[MW]};
        y_d   = '0;
        ovf_d = 1'b0;
        if (s2_spec_q) begin
            y_d = {s2_sign_q, EMAX, {MW{1'b0}}};
        end else if (!s2_sig_q[SW-1]) begin
            y_d = {s2_sign_q, {(EW+MW){1'b0}}};
        end else if (e3 >= {1'b0, EMAX}) begin
            y_d   = {s2_sign_q, EMAX, {MW{1'b0}}};
            ovf_d = 1'b1;
        end else begin
            y_d = {s2_sign_q, e3[EW-1:0], rnd[MW-1:0]};
        end
        zero_d = (y_d[W-2:0] == '0);
    end

    assign advance   = out_ready | ~vld_q[STAGES];
    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES];
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q  <= '0;
            y_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            vld_q          <= {vld_q[STAGES-1:1], in_valid};
            s1_big_q       <= s1_big_d;
            s1_small_q     <= s1_small_d;
            s1_exp_q       <= s1_exp_d;
            s1_sign_q      <= s1_sign_d;
            s1_sub_q       <= s1_sub_d;
            s1_spec_q      <= s1_spec_d;
            s1_spec_sign_q <= s1_spec_sign_d;
            s1_negz_q      <= s1_negz_d;
            s2_sig_q       <= s2_sig_d;
            s2_exp_q       <= s2_exp_d;
            s2_sign_q      <= s2_sign_d;
            s2_spec_q      <= s2_spec_d;
            // Bubbles present all-zero outputs
            y_q            <= vld_q[STAGES-1] ? y_d : '0;
            ovf_q          <= vld_q[STAGES-1] & ovf_d;
            zero_q         <= vld_q[STAGES-1] & zero_d;
        end
    end
endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe: single-precision vectors, backpressure,
// mid-flight reset and a half-precision instance.
module tb_fadd_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, in_valid, in_ready, sub, out_valid, out_ready, ovf, zero;
    logic [31:0] x1, x2, y;
    logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready, h_ovf, h_zero;
    logic [15:0] h_x1, h_x2, h_y;

    int errors = 0;
    int checks = 0;

    fadd_pipe #(.EW(8), .MW(23)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf), .zero(zero));

    fadd_pipe #(.EW(5), .MW(10)) dut_h (
        .clk(clk), .rstn(rstn), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .x1(h_x1), .x2(h_x2), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .y(h_y), .ovf(h_ovf), .zero(h_zero));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] ey, input logic eovf, input logic ezero);
        int lat;
        @(negedge clk);
        x1 = a; x2 = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_y"}, y, ey);
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        check({tag, "_zero"}, 32'(zero), 32'(ezero));
    endtask

    logic [31:0] bx1 [8];
    logic [31:0] bx2 [8];
    logic [31:0] by  [8];
    logic        bs  [8];

    initial begin
        int sent, rcv, stall_left, lat;
        bit stall_done;
        logic [31:0] held;

        bx1 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40000000, 32'h3F800000, 32'h40400000};
        bx2 = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000};
        bs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        by  = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                32'h40800000, 32'h00000000, 32'h3FC00000, 32'h40C00000};

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; x1 = '0; x2 = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_sub = 1'b0; h_x1 = '0; h_x2 = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        rstn = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run1("add_1p1",    32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        run1("cancel",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b1);
        run1("neg_sub",    32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 1'b0, 1'b0);
        run1("tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        run1("tie_odd",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0);
        run1("sticky",     32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0);
        run1("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        run1("inf_in",     32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0);
        run1("sub_norm",   32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 1'b0, 1'b0);
        run1("sub_swap",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0);
        run1("denorm_in",  32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        run1("underflow",  32'h00800000, 32'h00C00000, 1'b1, 32'h00000000, 1'b0, 1'b1);
        run1("negzero",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run1("poszero",    32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b0, 1'b1);

        // Backpressure: 8 back-to-back beats, 5-cycle stall at first result
        sent = 0; rcv = 0; stall_left = 0; stall_done = 1'b0; held = '0;
        for (int c = 0; c < 60 && rcv < 8; c++) begin
            @(negedge clk);
            if (out_valid && !stall_done) begin
                stall_done = 1'b1;
                stall_left = 5;
                held = y;
            end
            out_ready = (stall_left == 0);
            in_valid = (sent < 8);
            if (sent < 8) begin
                x1 = bx1[sent]; x2 = bx2[sent]; sub = bs[sent];
            end
            #1;
            if (stall_left > 0) begin
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_y_stable", y, held);
                stall_left--;
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_y%0d", rcv), y, by[rcv]);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("bp_count", 32'(rcv), 32'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x1 = bx1[i]; x2 = bx2[i]; sub = bs[i]; in_valid = 1'b1;
        end
        @(negedge clk);
        rstn = 1'b0; x1 = 32'h3F800000; x2 = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        rstn = 1'b1; in_valid = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_y", y, 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mrst_no_stale", 32'(out_valid), 32'd0);
        end

        // Half precision instance
        @(negedge clk);
        h_x1 = 16'h3C00; h_x2 = 16'h3C00; h_sub = 1'b0; h_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        h_in_valid = 1'b0;
        lat = 1;
        while (!h_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("h_lat", 32'(lat), 32'd3);
        check("h_y", {16'h0, h_y}, 32'h4000);
        check("h_ovf", 32'(h_ovf), 32'd0);
        check("h_zero", 32'(h_zero), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
